// File: rtl/dp_types_pkg.sv
// Shared types for the associative BTB: entry layout and saturating-counter encodings.
package dp_types_pkg;

  localparam int unsigned TAG_MAX = 30;
  localparam int unsigned CTR_MAX = 8;

  typedef logic [CTR_MAX-1:0] ctr_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    ctr_t               ctr;
  } entry_t;

  // Weakly-taken: MSB of a w-bit counter set, lower bits clear.
  function automatic ctr_t ctr_weak_taken(input int unsigned w);
    return ctr_t'(32'd1 << (w - 1));
  endfunction

  function automatic ctr_t ctr_max(input int unsigned w);
    return ctr_t'((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Lookup and resolved-branch update bundle for btb_assoc.
interface btb_assoc_if;
  logic [31:0] rpc;
  logic        phit;
  logic        ptaken;
  logic [31:0] ptarget;
  logic        wen;
  logic [31:0] wpc;
  logic        wtaken;
  logic [31:0] wtarget;
  logic        flush;

  modport btb (
    input  rpc, wen, wpc, wtaken, wtarget, flush,
    output phit, ptaken, ptarget
  );

  modport tb (
    output rpc, wen, wpc, wtaken, wtarget, flush,
    input  phit, ptaken, ptarget
  );
endinterface

// File: rtl/sat_counter.sv
// Combinational next value of a CTR_W-bit saturating up/down counter.
module sat_counter
  import dp_types_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  ctr_t value,
  input  logic inc,
  output ctr_t next_c
);

  localparam ctr_t MAX = ctr_max(CTR_W);

  always_comb begin
    next_c = value;
    if (inc) begin
      if (value < MAX) next_c = value + ctr_t'(1);
    end else begin
      if (value != '0) next_c = value - ctr_t'(1);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: zero-latency lookup, counter/target
// update on resolved branches, age-based LRU replacement.
module btb_assoc
  import dp_types_pkg::*;
#(
  parameter int unsigned SETS  = 4,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned CTR_W = 2
) (
  input logic      CLK,
  input logic      nRST,
  btb_assoc_if.btb bus
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam ctr_t        WEAK  = ctr_weak_taken(CTR_W);

  entry_t mem [SETS][WAYS];

  logic [IDX_W-1:0]   ridx, widx;
  logic [TAG_MAX-1:0] rtag, wtag;
  logic [WAYS-1:0]    rmatch, wmatch, winval;
  logic               whit;
  logic [WAY_W-1:0]   hway, vway;
  ctr_t               ctr_next;
  logic               unused_pc;

  assign ridx      = bus.rpc[IDX_W+1:2];
  assign widx      = bus.wpc[IDX_W+1:2];
  assign rtag      = TAG_MAX'(bus.rpc[31:IDX_W+2]);
  assign wtag      = TAG_MAX'(bus.wpc[31:IDX_W+2]);
  assign unused_pc = ^{bus.rpc[1:0], bus.wpc[1:0]};

  // Tag compare for both the lookup set and the update set.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rmatch[w] = mem[ridx][w].valid && (mem[ridx][w].tag == rtag);
      wmatch[w] = mem[widx][w].valid && (mem[widx][w].tag == wtag);
      winval[w] = !mem[widx][w].valid;
    end
  end

  // Lookup reads current state only; same-cycle updates are not bypassed.
  always_comb begin
    bus.phit    = 1'b0;
    bus.ptaken  = 1'b0;
    bus.ptarget = '0;
    if ($countones(rmatch) == 1) begin
      bus.phit = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if (rmatch[w]) begin
          bus.ptaken  = mem[ridx][w].ctr[CTR_W-1];
          bus.ptarget = mem[ridx][w].target;
        end
      end
    end
  end

  always_comb begin
    hway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (wmatch[w]) hway = WAY_W'(w);
    end
  end

  assign whit = |wmatch;

  sat_counter #(.CTR_W(CTR_W)) u_ctr (
    .value  (mem[widx][hway].ctr),
    .inc    (bus.wtaken),
    .next_c (ctr_next)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mem[s][w] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK};
        end
      end
    end else if (bus.flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mem[s][w].valid <= 1'b0;
        end
      end
    end else if (bus.wen) begin
      if (whit) begin
        mem[widx][hway].ctr <= ctr_next;
        if (bus.wtaken) mem[widx][hway].target <= bus.wtarget;
      end else if (bus.wtaken) begin
        mem[widx][vway] <= '{valid: 1'b1, tag: wtag, target: bus.wtarget, ctr: WEAK};
      end
    end
  end

  generate
    if (WAYS > 1) begin : g_lru
      logic [WAY_W-1:0] age [SETS][WAYS];
      logic [WAY_W-1:0] tway;
      logic             touch;

      assign touch = bus.wen && !bus.flush && (whit || bus.wtaken);
      assign tway  = whit ? hway : vway;

      // Victim: lowest invalid way, otherwise the oldest way.
      always_comb begin
        vway = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (age[widx][w] == WAY_W'(WAYS - 1)) vway = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (winval[w]) vway = WAY_W'(w);
        end
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
              age[s][w] <= WAY_W'(w);
            end
          end
        end else if (touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == tway) begin
              age[widx][w] <= '0;
            end else if (age[widx][w] < age[widx][tway]) begin
              age[widx][w] <= age[widx][w] + WAY_W'(1);
            end
          end
        end
      end
    end else begin : g_nolru
      assign vway = '0;
    end
  endgenerate

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (SETS=4, WAYS=2, CTR_W=2).
module tb_btb_assoc;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  btb_assoc_if bus ();

  btb_assoc #(.SETS(4), .WAYS(2), .CTR_W(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    logic        wen;
    logic [31:0] wpc;
    logic        wtaken;
    logic [31:0] wtarget;
    logic        flush;
    logic [31:0] rpc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } vec_t;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    string       name;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic wen, input logic [31:0] wpc, input logic wt,
                              input logic [31:0] wtg, input logic fl, input logic [31:0] rpc,
                              input logic h, input logic t, input logic [31:0] tg);
    vec_t v;
    v.wen = wen; v.wpc = wpc; v.wtaken = wt; v.wtarget = wtg; v.flush = fl;
    v.rpc = rpc; v.hit = h; v.taken = t; v.target = tg;
    return v;
  endfunction

  task automatic expect_out(input logic h, input logic t, input logic [31:0] tg, input string name);
    exp_t e;
    e.hit = h; e.taken = t; e.target = tg; e.name = name;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got output with no expectation queued");
    end else begin
      e = sb.pop_front();
      if (bus.phit !== e.hit || bus.ptaken !== e.taken || bus.ptarget !== e.target) begin
        errors++;
        $display("FAIL %s: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                 e.name, bus.phit, bus.ptaken, bus.ptarget, e.hit, e.taken, e.target);
      end
    end
  endtask

  task automatic idle_inputs();
    bus.wen = 1'b0; bus.wpc = '0; bus.wtaken = 1'b0; bus.wtarget = '0;
    bus.flush = 1'b0; bus.rpc = '0;
  endtask

  initial begin
    idle_inputs();
    bus.rpc = 32'h100;
    nRST = 1'b0;
    #1;
    expect_out(1'b0, 1'b0, 32'h0, "reset_state");
    check_out();

    //      wen  wpc       wt   wtarget   fl   rpc       hit  tk   target
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 0, 32'h000)); // 0 empty after reset
    tv.push_back(mk(1, 32'h100, 1, 32'h200, 0, 32'h100, 0, 0, 32'h000)); // 1 alloc, lookup pre-update
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h200)); // 2 ctr=10
    tv.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 1, 32'h200)); // 3 ctr->01
    tv.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 0, 32'h200)); // 4 ctr->00
    tv.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 0, 32'h200)); // 5 saturates at 00
    tv.push_back(mk(1, 32'h100, 1, 32'h300, 0, 32'h100, 1, 0, 32'h200)); // 6 ctr->01, target 300
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 0, 32'h300)); // 7
    tv.push_back(mk(1, 32'h100, 1, 32'h300, 0, 32'h100, 1, 0, 32'h300)); // 8 ctr->10
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h300)); // 9
    tv.push_back(mk(1, 32'h110, 1, 32'h400, 0, 32'h110, 0, 0, 32'h000)); // 10 alloc way1
    tv.push_back(mk(1, 32'h100, 1, 32'h300, 0, 32'h110, 1, 1, 32'h400)); // 11 touch 0x100
    tv.push_back(mk(1, 32'h120, 1, 32'h500, 0, 32'h100, 1, 1, 32'h300)); // 12 evicts 0x110
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h110, 0, 0, 32'h000)); // 13
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h120, 1, 1, 32'h500)); // 14
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h300)); // 15
    tv.push_back(mk(1, 32'h104, 0, 32'h600, 0, 32'h104, 0, 0, 32'h000)); // 16 NT miss writes nothing
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 0, 32'h000)); // 17
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h102, 1, 1, 32'h300)); // 18 pc[1:0] ignored
    tv.push_back(mk(1, 32'h104, 1, 32'h700, 0, 32'h000, 0, 0, 32'h000)); // 19 set1 alloc
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h107, 1, 1, 32'h700)); // 20
    tv.push_back(mk(1, 32'h130, 1, 32'h800, 0, 32'h120, 1, 1, 32'h500)); // 21 evicts 0x100 (lookups no LRU)
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h120, 1, 1, 32'h500)); // 22
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 0, 32'h000)); // 23
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h130, 1, 1, 32'h800)); // 24
    tv.push_back(mk(1, 32'h140, 1, 32'h900, 1, 32'h120, 1, 1, 32'h500)); // 25 flush beats wen
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h120, 0, 0, 32'h000)); // 26
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h130, 0, 0, 32'h000)); // 27
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 0, 32'h000)); // 28
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h140, 0, 0, 32'h000)); // 29
    tv.push_back(mk(1, 32'h120, 1, 32'hA00, 0, 32'h000, 0, 0, 32'h000)); // 30 realloc after flush
    tv.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h120, 1, 1, 32'hA00)); // 31

    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Inputs change on the falling edge; outputs sampled before the rising edge.
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge CLK);
      bus.wen = tv[i].wen; bus.wpc = tv[i].wpc; bus.wtaken = tv[i].wtaken;
      bus.wtarget = tv[i].wtarget; bus.flush = tv[i].flush; bus.rpc = tv[i].rpc;
      expect_out(tv[i].hit, tv[i].taken, tv[i].target, $sformatf("vec%0d", i));
      #2;
      check_out();
    end

    // Asynchronous reset mid-operation, with an update held across it.
    @(negedge CLK);
    idle_inputs();
    bus.rpc = 32'h120;
    expect_out(1'b1, 1'b1, 32'hA00, "pre_reset_hit");
    #2;
    check_out();
    #1;
    nRST = 1'b0;
    bus.wen = 1'b1; bus.wpc = 32'h150; bus.wtaken = 1'b1; bus.wtarget = 32'hB00;
    #1;
    expect_out(1'b0, 1'b0, 32'h0, "reset_immediate");
    check_out();
    @(posedge CLK);
    #1;
    expect_out(1'b0, 1'b0, 32'h0, "reset_held");
    check_out();
    @(negedge CLK);
    nRST = 1'b1;
    bus.wen = 1'b0;
    bus.rpc = 32'h150;
    expect_out(1'b0, 1'b0, 32'h0, "reset_update_discarded");
    #2;
    check_out();
    @(negedge CLK);
    bus.rpc = 32'h120;
    expect_out(1'b0, 1'b0, 32'h0, "reset_cleared_entry");
    #2;
    check_out();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
- REQ-001 The block SHALL take parameter SETS, default 4, as the number of sets (power of two, 2..64).
- REQ-002 The block SHALL take parameter WAYS, default 2, as the associativity (power of two, 1..4).
- REQ-003 The block SHALL take parameter CTR_W, default 2, as the saturating-counter width.
- REQ-004 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
- REQ-005 The block SHALL have port nRST, input, 1, the asynchronous active-low reset.
- REQ-006 The block SHALL have port rpc, input, 32, the fetch PC to look up.
- REQ-007 The block SHALL have port phit, output, 1, asserted when rpc matches a valid entry.
- REQ-008 The block SHALL have port ptaken, output, 1, the predict-taken flag.
- REQ-009 The block SHALL have port ptarget, output, 32, the predicted target (0 when phit=0).
- REQ-010 The block SHALL have port wen, input, 1, a resolved-branch update strobe.
- REQ-011 The block SHALL have port wpc, input, 32, the PC of the resolved branch.
- REQ-012 The block SHALL have port wtaken, input, 1, the actual branch outcome.
- REQ-013 The block SHALL have port wtarget, input, 32, the actual branch target.
- REQ-014 The block SHALL have port flush, input, 1, a synchronous invalidate of all entries.

Function
- REQ-015 The block SHALL derive index = pc[IDX_W+1:2] and tag = pc[31:IDX_W+2], where IDX_W = log2(SETS); pc[1:0] SHALL be ignored.
- REQ-016 The lookup SHALL be combinational (zero latency); phit=1 iff exactly one valid way in set(rpc) has a matching tag.
- REQ-017 When phit=1, ptaken SHALL equal counter MSB and ptarget the stored target; when phit=0, ptaken=0 and ptarget=0.
- REQ-018 An update SHALL occur only on a CLK edge with wen=1 and flush=0.
- REQ-019 On an update hit, the counter SHALL saturating-increment if wtaken else saturating-decrement (no wrap past all-ones or zero).
- REQ-020 On an update hit with wtaken=1, the target SHALL be overwritten with wtarget.
- REQ-021 On an update miss with wtaken=1, the block SHALL allocate the lowest-numbered invalid way, else the LRU way, writing valid=1, tag, wtarget, and counter=weakly-taken (MSB=1, rest 0).
- REQ-022 On an update miss with wtaken=0, the block SHALL write nothing.
- REQ-023 LRU SHALL use per-way age fields of log2(WAYS) bits per set: the touched way gets age 0, and ways younger than its old age increment; ages SHALL remain a permutation at all times.
- REQ-024 LRU SHALL be updated only by updates (hit or allocate), never by lookups.
- REQ-025 When lookup and update target the same set in the same cycle, the lookup SHALL return pre-update contents (no bypass).
- REQ-026 flush=1 SHALL clear all valid bits at the next edge, take precedence over wen, and leave ages, tags, targets and counters unchanged.
- REQ-027 With WAYS=1, LRU logic SHALL reduce to nothing and allocation SHALL always replace way 0.

Reset
- REQ-028 nRST low SHALL immediately clear all valid bits, set all counters to weakly-taken, zero all tags and targets, and set way w's age to w in every set.
- REQ-029 Outputs SHALL read phit=0, ptaken=0, ptarget=0 while reset is asserted, including when reset occurs mid-operation; an update coincident with reset SHALL be discarded.

Structure
- REQ-030 The entry struct (valid, tag, target, counter) and the counter-encoding constants SHALL live in dp_types_pkg.
- REQ-031 A matching interface, btb_assoc_if, SHALL provide btb and tb modports.
- REQ-032 A sub-module sat_counter (parametrised by CTR_W, combinational next-value of inc/dec) SHALL be instantiated per update path.

Verification (SETS=4, WAYS=2)
- REQ-033 Reset then lookup of rpc=0x100 SHALL return phit=0, ptaken=0, ptarget=0.
- REQ-034 An update of wpc=0x100 with wtaken=1 and wtarget=0x200, followed next cycle by lookup of rpc=0x100, SHALL return phit=1, ptaken=1, ptarget=0x200.
- REQ-035 Two not-taken updates to 0x100 SHALL give counter=00 and ptaken=0 with phit=1; a third not-taken update SHALL keep the counter at 00.
- REQ-036 Taken updates to 0x100, 0x110, then 0x100, then 0x120 (all set 0) SHALL evict 0x110: lookups then give phit=1 for 0x100 and 0x120 and phit=0 for 0x110.
- REQ-037 With wen to 0x100 asserted together with lookup of 0x100, the same-cycle lookup SHALL show the old value, and the next cycle SHALL show the new value.
- REQ-038 flush together with wen, followed by lookups of all previously valid PCs, SHALL return phit=0; an nRST pulse mid-sequence SHALL return all outputs to zero immediately.
